// File: rtl/lightboard_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lightboard_link_pkg
//  Brief    : Shared definitions for the FPGA1->FPGA2 dibit pixel link.
//  Revision : 1.0  initial release
// ============================================================================
package lightboard_link_pkg;

    typedef enum logic [1:0] {
        RxAddress = 2'd0,
        RxPixel   = 2'd1,
        RxTail    = 2'd2,
        RxDiscard = 2'd3
    } rx_state_t;

    localparam int ADDR_DIBITS               = 12;
    localparam int DIBITS_PER_BYTE           = 4;
    localparam int ADDR_BYTES                = ADDR_DIBITS / DIBITS_PER_BYTE;
    localparam int PIXEL_ADDR_W              = 17;
    localparam int DEFAULT_FRAME_PIXELS      = 76800;
    localparam int DEFAULT_PIXELS_PER_PACKET = 320;

    // Frame-buffer address step with wrap at the end of the frame.
    function automatic logic [PIXEL_ADDR_W-1:0] next_pixel_addr(
        input logic [PIXEL_ADDR_W-1:0] addr,
        input int                      frame_pixels
    );
        return (int'(addr) == frame_pixels - 1) ? '0 : addr + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dibit_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : dibit_byte_assembler
//  Brief    : Collects four LSB-first dibits into one byte.
//  Revision : 1.0  initial release
// ============================================================================
module dibit_byte_assembler
    import lightboard_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       dibit_valid,
    input  logic [1:0] dibit,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       partial
);

    logic [1:0] r_count;
    logic [5:0] r_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_low   <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (dibit_valid) begin
            case (r_count)
                2'd0:    r_low[1:0] <= dibit;
                2'd1:    r_low[3:2] <= dibit;
                2'd2:    r_low[5:4] <= dibit;
                default: ;
            endcase
            r_count <= r_count + 2'd1;
        end
    end

    // The fourth dibit is combined straight from the input so the byte is
    // usable in the same cycle it completes.
    assign byte_out   = {dibit, r_low};
    assign byte_valid = dibit_valid && !clear && (r_count == 2'(DIBITS_PER_BYTE - 1));
    assign partial    = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: rtl/pixel_stream_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_receiver
//  Brief    : Deserialises the dibit pixel link into frame-buffer writes.
//             Optional trailing-byte output enabled by AUDIO_CAPTURE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_stream_receiver
    import lightboard_link_pkg::*;
#(
    parameter int PIXELS_PER_PACKET = DEFAULT_PIXELS_PER_PACKET,
    parameter int FRAME_PIXELS      = DEFAULT_FRAME_PIXELS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    axiiv,
    input  logic [1:0]              axiid,
    output logic [PIXEL_ADDR_W-1:0] pixel_addr,
    output logic [7:0]              pixel_data,
    output logic                    pixel_valid,
    output logic                    packet_done,
    output logic                    err
`ifdef AUDIO_CAPTURE_EN
    ,
    output logic [7:0]              audio_data,
    output logic                    audio_valid
`endif
);

    localparam int c_PIX_CNT_W = (PIXELS_PER_PACKET > 1) ? $clog2(PIXELS_PER_PACKET) : 1;

    rx_state_t               r_state;
    logic                    r_armed;
    logic [15:0]             r_addr_hi;
    logic [1:0]              r_addr_idx;
    logic [PIXEL_ADDR_W-1:0] r_addr_cnt;
    logic [c_PIX_CNT_W-1:0]  r_pix_cnt;

    logic       w_take;
    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_partial;
    logic [23:0] w_addr_full;
    logic       w_addr_bad;

    // Nothing is accepted until the link has been seen idle after reset.
    assign w_take      = axiiv && r_armed;
    assign w_addr_full = {r_addr_hi, w_byte};
    assign w_addr_bad  = (|w_addr_full[23:17]) || (w_addr_full >= 24'(FRAME_PIXELS));

    dibit_byte_assembler u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (!w_take),
        .dibit_valid(w_take),
        .dibit      (axiid),
        .byte_out   (w_byte),
        .byte_valid (w_byte_valid),
        .partial    (w_partial)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RxAddress;
            r_armed     <= 1'b0;
            r_addr_hi   <= '0;
            r_addr_idx  <= '0;
            r_addr_cnt  <= '0;
            r_pix_cnt   <= '0;
            pixel_addr  <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            packet_done <= 1'b0;
            err         <= 1'b0;
`ifdef AUDIO_CAPTURE_EN
            audio_data  <= '0;
            audio_valid <= 1'b0;
`endif
        end else begin
            pixel_valid <= 1'b0;
            packet_done <= 1'b0;
            err         <= 1'b0;
`ifdef AUDIO_CAPTURE_EN
            audio_valid <= 1'b0;
`endif
            if (!axiiv) begin
                r_armed <= 1'b1;
            end

            if (!w_take) begin
                // End of packet (or not yet armed): flag an incomplete header
                // or pixel run, then return to waiting for an address.
                case (r_state)
                    RxAddress: err <= (r_addr_idx != 2'd0) || w_partial;
                    RxPixel:   err <= 1'b1;
                    default:   ;
                endcase
                r_state    <= RxAddress;
                r_addr_hi  <= '0;
                r_addr_idx <= '0;
                r_pix_cnt  <= '0;
            end else if (w_byte_valid) begin
                case (r_state)
                    RxAddress: begin
                        if (r_addr_idx == 2'(ADDR_BYTES - 1)) begin
                            r_addr_idx <= '0;
                            if (w_addr_bad) begin
                                err     <= 1'b1;
                                r_state <= RxDiscard;
                            end else begin
                                r_addr_cnt <= w_addr_full[PIXEL_ADDR_W-1:0];
                                r_pix_cnt  <= '0;
                                r_state    <= RxPixel;
                            end
                        end else begin
                            r_addr_hi  <= {r_addr_hi[7:0], w_byte};
                            r_addr_idx <= r_addr_idx + 2'd1;
                        end
                    end
                    RxPixel: begin
                        pixel_valid <= 1'b1;
                        pixel_addr  <= r_addr_cnt;
                        pixel_data  <= w_byte;
                        r_addr_cnt  <= next_pixel_addr(r_addr_cnt, FRAME_PIXELS);
                        if (r_pix_cnt == c_PIX_CNT_W'(PIXELS_PER_PACKET - 1)) begin
                            packet_done <= 1'b1;
                            r_pix_cnt   <= '0;
                            r_state     <= RxTail;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                    RxTail: begin
`ifdef AUDIO_CAPTURE_EN
                        audio_valid <= 1'b1;
                        audio_data  <= w_byte;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
